fir_smpl_queue: RTL and testbench



---
 rtl/fir_smpl_queue.sv | 123 ++++++++++++
 tb/tb_fir_smpl_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_smpl_queue.sv
// Circular sample buffer feeding the FIR MAC core: keeps the last DEPTH samples and,
// after each committed sample, streams them oldest-to-newest one per clock.
module fir_smpl_queue #(
  parameter int DEPTH  = 1021,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic [DATA_W-1:0] new_smpl,
  output logic [DATA_W-1:0] smpl_out,
  output logic              sequencing,
  output logic              full,
  output logic              ovr
);
  localparam int PTR_W = 10;
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] SEQ_LEN   = PTR_W'(DEPTH);

  typedef enum logic [1:0] {FILL, WAIT, SEQ} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [0:(1<<PTR_W)-1];
  logic [PTR_W-1:0]  new_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  fill_cnt;
  logic [PTR_W-1:0]  seq_cnt;
  logic [PTR_W-1:0]  new_ptr_inc;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [DATA_W-1:0] pend_data;
  logic              pend_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  assign new_ptr_inc = (new_ptr == LAST_ADDR) ? '0 : new_ptr + 1'b1;
  assign rd_ptr_inc  = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;

  // RAM is only written outside SEQ, so a write never collides with a stream read.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = new_smpl;
    case (state)
      FILL: wr_en = wrt_smpl;
      WAIT: begin
        if (pend_valid) begin
          wr_en   = 1'b1;
          wr_data = pend_data;
        end else begin
          wr_en = wrt_smpl;
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[new_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      new_ptr    <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      seq_cnt    <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      smpl_out   <= '0;
      sequencing <= 1'b0;
      full       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (wr_en) new_ptr <= new_ptr_inc;
      case (state)
        FILL: begin
          if (wrt_smpl) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_ADDR) begin
              full       <= 1'b1;
              state      <= SEQ;
              sequencing <= 1'b1;
              rd_ptr     <= new_ptr_inc;
              seq_cnt    <= '0;
            end
          end
        end
        WAIT: begin
          // A pending sample is consumed here; a strobe in the same cycle refills pending.
          if (pend_valid) begin
            pend_valid <= wrt_smpl;
            if (wrt_smpl) pend_data <= new_smpl;
          end
          if (wr_en) begin
            state      <= SEQ;
            sequencing <= 1'b1;
            rd_ptr     <= new_ptr_inc;
            seq_cnt    <= '0;
          end
        end
        SEQ: begin
          if (wrt_smpl) begin
            if (pend_valid) begin
              ovr <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_data  <= new_smpl;
            end
          end
          if (seq_cnt == SEQ_LEN) begin
            sequencing <= 1'b0;
            state      <= WAIT;
          end else begin
            smpl_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr_inc;
            seq_cnt  <= seq_cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_smpl_queue.sv
// Bench for fir_smpl_queue: a window-based reference model fills a scoreboard that a
// negedge monitor drains while also checking sequencing/full/ovr every cycle.
module tb_fir_smpl_queue;
  localparam int DEPTH  = 1021;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wrt_smpl = 1'b0;
  logic [DATA_W-1:0] new_smpl = '0;
  logic [DATA_W-1:0] smpl_out;
  logic              sequencing;
  logic              full;
  logic              ovr;

  fir_smpl_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .new_smpl   (new_smpl),
    .smpl_out   (smpl_out),
    .sequencing (sequencing),
    .full       (full),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model state: sample history, pending slot, start cycle of latest stream.
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] pend[$];
  logic [DATA_W-1:0] exp_q[$];
  bit m_full = 0;
  bit m_ovr  = 0;
  int seq_s  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic commit(input logic [DATA_W-1:0] v);
    hist.push_back(v);
    if (hist.size() > DEPTH) void'(hist.pop_front());
  endtask

  task automatic start_stream(input int s);
    seq_s = s;
    foreach (hist[i]) exp_q.push_back(hist[i]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      pend.delete();
      exp_q.delete();
      m_full = 0;
      m_ovr  = 0;
      seq_s  = -1;
    end else if (!m_full) begin
      if (wrt_smpl) begin
        commit(new_smpl);
        if (hist.size() == DEPTH) begin
          m_full = 1;
          start_stream(cyc + 1);
        end
      end
    end else if (cyc <= seq_s + DEPTH) begin
      if (wrt_smpl) begin
        if (pend.size() != 0) m_ovr = 1;
        else pend.push_back(new_smpl);
      end
    end else if (cyc == seq_s + DEPTH + 1 && pend.size() != 0) begin
      commit(pend.pop_front());
      start_stream(cyc + 1);
      if (wrt_smpl) pend.push_back(new_smpl);
    end else if (wrt_smpl) begin
      commit(new_smpl);
      start_stream(cyc + 1);
    end
    cyc++;
  end

  // Monitor: data is valid on every sequencing cycle except the first of a stream.
  bit seq_prev = 0;
  int seq_count = 0;
  always @(negedge clk) begin
    if (rst) begin
      seq_prev = 0;
    end else begin
      bit exp_seq;
      exp_seq = (seq_s >= 0) && (cyc >= seq_s) && (cyc <= seq_s + DEPTH);
      chk("sequencing", 32'(sequencing), 32'(exp_seq));
      chk("full", 32'(full), 32'(m_full));
      chk("ovr", 32'(ovr), 32'(m_ovr));
      if (sequencing && seq_prev) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'(1), 32'(0));
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          chk("smpl_out", 32'(smpl_out), 32'(e));
        end
      end
      if (seq_prev && !sequencing) begin
        seq_count++;
        $display("stream %0d finished at cycle %0d, last sample %0d", seq_count, cyc, $signed(smpl_out));
      end
      seq_prev = sequencing;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] v);
    wrt_smpl = 1'b1;
    new_smpl = v;
    tick();
    wrt_smpl = 1'b0;
  endtask

  task automatic wait_to(input int c);
    for (int i = 0; i < 20000 && cyc < c; i++) tick();
    if (cyc < c) chk("wait_timeout", 32'(cyc), 32'(c));
  endtask

  initial begin
    int s;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_smpl_out", 32'(smpl_out), 32'(0));
    chk("reset_sequencing", 32'(sequencing), 32'(0));

    // Fill with 1..1020 spaced four cycles apart, then the filling strobe.
    for (int v = 1; v < DEPTH; v++) begin
      strobe(DATA_W'(v));
      repeat (3) tick();
    end
    chk("prefill_full", 32'(full), 32'(0));
    strobe(DATA_W'(DEPTH));
    chk("full_after_fill", 32'(full), 32'(1));

    // Wraparound stream ending in a negative sample.
    wait_to(seq_s + DEPTH + 5);
    strobe(-16'sd5);
    s = seq_s;

    // Mid-stream arrival is held and committed after the stream.
    wait_to(s + 300);
    strobe(16'd77);
    wait_to(s + DEPTH + 3);
    s = seq_s;

    // Two arrivals within one stream: the second is dropped.
    wait_to(s + 100);
    strobe(DATA_W'($urandom));
    wait_to(s + 200);
    strobe(DATA_W'($urandom));
    chk("ovr_set", 32'(ovr), 32'(1));

    // Arrival exactly in the commit cycle while a sample is pending.
    wait_to(s + DEPTH + 1);
    strobe(DATA_W'($urandom));
    wait_to(s + 2 * DEPTH + 10);

    // Randomly spaced arrivals.
    repeat (10) begin
      repeat ($urandom_range(1, 1300)) tick();
      strobe(DATA_W'($urandom));
    end
    wait_to(cyc + 2 * DEPTH + 10);

    // Arrival in the commit cycle with nothing pending.
    strobe(DATA_W'($urandom));
    s = seq_s;
    wait_to(s + DEPTH + 1);
    strobe(DATA_W'($urandom));
    wait_to(seq_s + DEPTH + 5);

    // Asynchronous reset in the middle of a stream.
    strobe(DATA_W'($urandom));
    s = seq_s;
    wait_to(s + 500);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_smpl_out", 32'(smpl_out), 32'(0));
    chk("async_rst_sequencing", 32'(sequencing), 32'(0));
    chk("async_rst_full", 32'(full), 32'(0));
    chk("async_rst_ovr", 32'(ovr), 32'(0));
    tick();
    rst = 1'b0;

    // Refill required before streaming resumes.
    for (int v = 1; v < DEPTH; v++) begin
      strobe(DATA_W'($urandom));
      tick();
    end
    chk("refill_no_seq", 32'(sequencing), 32'(0));
    strobe(DATA_W'($urandom));
    chk("refill_full", 32'(full), 32'(1));
    wait_to(seq_s + DEPTH + 5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
